// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply-divide issue stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: E-stage md opcode encodings, 2-bit unit operation codes,
// issue FSM state encodings, default word width, opcode classifiers.

`ifndef MD_WORD
`define MD_WORD 32
`endif

package md_issue_ctrl_pkg;

    localparam int MD_WORD_W = `MD_WORD;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULTU = 4'd1,
        MD_MULT  = 4'd2,
        MD_DIVU  = 4'd3,
        MD_DIV   = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam logic [1:0] MULOP_MULTU = 2'b00;
    localparam logic [1:0] MULOP_MULT  = 2'b01;
    localparam logic [1:0] MULOP_DIVU  = 2'b10;
    localparam logic [1:0] MULOP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } md_state_e;

    // Any op that touches HI/LO, including the reads.
    function automatic logic is_md_class(input logic [3:0] op);
        return (op >= MD_MULTU) && (op <= MD_MFLO);
    endfunction

    // Ops that need the unit or a HI/LO write; reads never need issuing.
    function automatic logic is_issuable(input logic [3:0] op);
        return (op >= MD_MULTU) && (op <= MD_MTLO);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

    function automatic logic [1:0] mulop_of(input logic [3:0] op);
        logic [1:0] code;
        code = MULOP_MULTU;
        case (op)
            MD_MULT: code = MULOP_MULT;
            MD_DIVU: code = MULOP_DIVU;
            MD_DIV:  code = MULOP_DIV;
            default: code = MULOP_MULTU;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Counts cycles spent waiting on the multiply-divide unit and flags a hang.
// Latency: expire_o is combinational in the wait cycle; err_o rises the next cycle.
// Backpressure: none; the counter clears whenever en_i is low.
//
// Ports: en_i (issue FSM is in WAIT), busy_i (unit busy),
//        first_o (current WAIT cycle is the first), expire_o (give up now),
//        err_o (sticky hang flag, cleared only by reset).

module md_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic busy_i,
    output logic first_o,
    output logic expire_o,
    output logic err_o
);

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       hit;

    // cnt_q holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle sees TIMEOUT-1.
    assign hit     = en_i && (cnt_q == 4'(TIMEOUT - 1));
    assign first_o = (cnt_q == 4'd0);
    // Busy is not yet meaningful on the first cycle, so a first-cycle hit
    // (TIMEOUT == 1) expires regardless; later only a still-busy unit expires.
    assign expire_o = hit && (first_o || busy_i);

    always_comb begin
        cnt_d = en_i ? (cnt_q + 4'd1) : 4'd0;
        err_d = err_q | expire_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard stage in front of the HI/LO multiply-divide unit.
// Latency: op accepted in cycle N -> md_start / md_mt_we / div0 in N+1.
// Backpressure: stall_e holds E while an md op is in flight (ISSUE/WAIT).
//
// Ports: e_* from the E stage (valid, op, flush, operands), md_busy_i from
//        the unit; md_start/md_mulop/md_a/md_b drive the unit, md_mt_we/
//        md_mt_hi write HI/LO directly, stall_e_o back to the pipeline,
//        div0_o flags a suppressed divide by zero, md_err_o a hung unit.

module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int WIDTH   = MD_WORD_W,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             e_valid_i,
    input  logic [3:0]       e_md_op_i,
    input  logic             e_flush_i,
    input  logic [WIDTH-1:0] e_srca_i,
    input  logic [WIDTH-1:0] e_srcb_i,
    input  logic             md_busy_i,
    output logic             md_start_o,
    output logic [1:0]       md_mulop_o,
    output logic             md_mt_we_o,
    output logic             md_mt_hi_o,
    output logic [WIDTH-1:0] md_a_o,
    output logic [WIDTH-1:0] md_b_o,
    output logic             stall_e_o,
    output logic             div0_o,
    output logic             md_err_o
);

    md_state_e        state_q;
    logic             start_q;
    logic [1:0]       mulop_q;
    logic             mt_we_q;
    logic             mt_hi_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             div0_q;

    logic acc;
    logic div_by_zero;
    logic wd_first, wd_expire;

    // Flush outranks acceptance, and only IDLE can take a new op.
    assign acc = e_valid_i && !e_flush_i && (state_q == ST_IDLE)
                 && is_issuable(e_md_op_i);
    assign div_by_zero = is_div(e_md_op_i) && (e_srcb_i == '0);

    md_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (state_q == ST_WAIT),
        .busy_i   (md_busy_i),
        .first_o  (wd_first),
        .expire_o (wd_expire),
        .err_o    (md_err_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            mulop_q <= 2'b00;
            mt_we_q <= 1'b0;
            mt_hi_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; they are set only for one cycle.
            start_q <= 1'b0;
            mt_we_q <= 1'b0;
            div0_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        a_q <= e_srca_i;
                        b_q <= e_srcb_i;
                        if (div_by_zero) begin
                            div0_q <= 1'b1;
                        end else if (is_mt(e_md_op_i)) begin
                            mt_we_q <= 1'b1;
                            mt_hi_q <= (e_md_op_i == MD_MTHI);
                            state_q <= ST_ISSUE;
                        end else begin
                            start_q <= 1'b1;
                            mulop_q <= mulop_of(e_md_op_i);
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // start_q is high here exactly when the issued op uses the unit.
                    state_q <= start_q ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    // The unit raises busy one cycle after start, so busy low
                    // on the first WAIT cycle means nothing yet.
                    if ((!wd_first && !md_busy_i) || wd_expire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md_start_o = start_q;
    assign md_mulop_o = mulop_q;
    assign md_mt_we_o = mt_we_q;
    assign md_mt_hi_o = mt_hi_q;
    assign md_a_o     = a_q;
    assign md_b_o     = b_q;
    assign div0_o     = div0_q;

    // Must react to the op currently in E, so this one is combinational.
    assign stall_e_o = (state_q != ST_IDLE) && e_valid_i && is_md_class(e_md_op_i);

endmodule
